// File: rtl/entropy_bus_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : entropy_bus_driver_if
// Description : Loader-side sample handshake plus the held entropy bus and
//               its status outputs, bundled for the entropy bus driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface entropy_bus_driver_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sample_valid;
    logic [15:0]   sample_data;
    logic          sample_ready;
    logic          enable;
    logic [15:0]   external_entropy_out;
    logic          entropy_update;
    logic          src_is_lfsr;
    logic [CW-1:0] fifo_count;
    logic [15:0]   underrun_count;

    // Loader / consumer side
    modport master (
        output sample_valid, sample_data, enable,
        input  sample_ready, external_entropy_out, entropy_update,
               src_is_lfsr, fifo_count, underrun_count
    );

    // Driver side
    modport slave (
        input  sample_valid, sample_data, enable,
        output sample_ready, external_entropy_out, entropy_update,
               src_is_lfsr, fifo_count, underrun_count
    );
endinterface
`default_nettype wire

// File: rtl/entropy_bus_driver.sv
`default_nettype none
// ============================================================================
// Module      : entropy_bus_driver
// Description : Buffers loader samples in a FIFO and presents them on a held
//               16-bit entropy bus, refreshed every HOLD_CYCLES cycles. An
//               empty FIFO is covered by a 16-bit Fibonacci LFSR, and each
//               substitution is counted in a saturating underrun counter.
// Revision    : 1.0 - initial release
// ============================================================================
module entropy_bus_driver #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    entropy_bus_driver_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HW-1:0] c_HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] c_DEPTH       = CW'(FIFO_DEPTH);
    // An all-zero seed would lock the LFSR at zero forever
    localparam logic [15:0]   c_SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   bus_q, bus_d;
    logic          upd_q, upd_d;
    logic          src_q, src_d;
    logic [15:0]   under_q, under_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic w_ready, w_push, w_load, w_pop, w_fb;

    // Ready is taken from the registered count only; a full FIFO cannot
    // accept even when a pop happens in the same cycle.
    assign w_ready = (count_q < c_DEPTH);
    assign w_push  = bus.sample_valid && w_ready;
    assign w_load  = bus.enable && ((state_q == S_IDLE) || (hold_q == '0));
    assign w_pop   = w_load && (count_q != '0);
    assign w_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Next-state logic for the hold FSM, bus value, LFSR and counters
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bus_d   = bus_q;
        upd_d   = 1'b0;
        src_d   = src_q;
        under_d = under_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;

        if (!bus.enable) begin
            state_d = S_IDLE;
        end else if (w_load) begin
            state_d = S_HOLD;
            hold_d  = c_HOLD_RELOAD;
            upd_d   = 1'b1;
            if (w_pop) begin
                bus_d = mem[rptr_q];
                src_d = 1'b0;
            end else begin
                bus_d  = lfsr_q;
                src_d  = 1'b1;
                lfsr_d = {lfsr_q[14:0], w_fb};
                if (under_q != 16'hFFFF) begin
                    under_d = under_q + 16'd1;
                end
            end
        end else begin
            hold_d = hold_q - HW'(1);
        end

        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Sample storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wptr_q] <= bus.sample_data;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            bus_q   <= '0;
            upd_q   <= 1'b0;
            src_q   <= 1'b0;
            under_q <= '0;
            lfsr_q  <= c_SEED;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            bus_q   <= bus_d;
            upd_q   <= upd_d;
            src_q   <= src_d;
            under_q <= under_d;
            lfsr_q  <= lfsr_d;
            if (w_push) begin
                wptr_q <= (wptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= (rptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            end
        end
    end

    assign bus.sample_ready         = w_ready;
    assign bus.external_entropy_out = bus_q;
    assign bus.entropy_update       = upd_q;
    assign bus.src_is_lfsr          = src_q;
    assign bus.fifo_count           = count_q;
    assign bus.underrun_count       = under_q;
endmodule
`default_nettype wire
